heatmap_buffer_reader: RTL
==========================

Name: heatmap_buffer_reader

Overview:
Consumer end of the grid color-buffer write interface. It starts one compute/write pass by pulsing comp_allow, then waits for done_write_sig. It then reads the 8-bit RRR_GGG_BB color entries back out of the shared dual-port color RAM. Each node is expanded into a SCALE x SCALE pixel square and streamed to the VGA pixel writer over a valid/ready handshake.

Parameters:
NUM_NODES, 64, entries read per frame (nodes in the column); legal 1..256.
BASE_ADDR, 0, first RAM address read; addresses BASE_ADDR..BASE_ADDR+NUM_NODES-1; must not exceed 255.
RD_LAT, 2, RAM read latency in cycles (address to data).
SCALE, 4, pixel square edge per node; legal 1..8.
COLUMN, 31, column index of the node column on screen.
X_ORIGIN, 0, screen x of column 0.
Y_ORIGIN, 0, screen y of node 0.
DONE_TIMEOUT, 16'hFFFF, cycles to wait for done_write_sig before flagging an error.

Ports:
clk_50  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
frame_req  in  1  level; while high, the block runs frames back-to-back.
comp_allow  out  1  one-cycle pulse that starts a writer pass.
done_write_sig  in  1  one-cycle pulse from the writer marking the buffer complete.
rd_addr  out  8  color RAM read address.
rd_data  in  8  color RAM read data, valid RD_LAT cycles after rd_addr.
pixel_x  out  10  screen x.
pixel_y  out  10  screen y.
pixel_color  out  8  RRR_GGG_BB color.
pixel_valid  out  1  pixel presented.
pixel_ready  in  1  pixel writer accepts.
frame_done  out  1  one-cycle pulse after the last pixel is accepted.
frame_count  out  16  completed frames; wraps from 16'hFFFF to 0.
timeout_err  out  1  sticky; set on writer timeout, cleared only by reset.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE. comp_allow=0, rd_addr=BASE_ADDR, pixel_x/y=0, pixel_color=0, pixel_valid=0, frame_done=0, frame_count=0, timeout_err=0, all counters 0.
- IDLE: if frame_req==1, go to KICK. Otherwise stay.
- KICK: comp_allow=1 for exactly this cycle; clear the timeout counter; go to WAIT_DONE.
  - done_write_sig sampled in the KICK cycle is ignored, because the writer clears it on comp_allow.
- WAIT_DONE: if done_write_sig==1, set node=0 and go to RD_ISSUE. Otherwise increment the timeout counter.
  - When the counter reaches DONE_TIMEOUT: set timeout_err=1 and go to IDLE, with no pixels emitted.
- RD_ISSUE: rd_addr=BASE_ADDR+node; clear the latency counter; go to RD_WAIT.
- RD_WAIT: hold for RD_LAT cycles, then latch rd_data into the color register; set sx=sy=0; go to EMIT.
  - Exactly RD_LAT cycles separate the rd_addr update from the capture edge.
- EMIT: drive pixel_valid=1 with:
  - pixel_x = X_ORIGIN + COLUMN*SCALE + sx
  - pixel_y = Y_ORIGIN + node*SCALE + sy
  - pixel_color = latched color.
  - Arithmetic is unsigned, truncated to 10 bits.
  - All pixel outputs stay stable while pixel_valid=1 and pixel_ready=0.
  - On handshake (valid&ready): advance sx; on sx==SCALE-1, set sx=0 and advance sy.
  - After sx==sy==SCALE-1 is accepted, go to NEXT. In that transition cycle pixel_valid=0 (no back-to-back across nodes).
- NEXT: if node==NUM_NODES-1, go to FRAME_END. Otherwise node+1 and go to RD_ISSUE.
- FRAME_END: frame_done=1 for one cycle; frame_count+1 (wraps); go to IDLE.
  - frame_req still high gives KICK on the next cycle, so frame-to-frame gap = 2 cycles.
- Throughput with pixel_ready tied high: per node, 1 + RD_LAT + SCALE*SCALE + 1 cycles.
- frame_req dropping mid-frame has no effect; the current frame completes.
- A spurious done_write_sig outside WAIT_DONE is ignored.
- rd_addr holds its last value outside RD_ISSUE.

Decomposition:
- Shared package heatmap_pkg holds:
  - state encoding (IDLE, KICK, WAIT_DONE, RD_ISSUE, RD_WAIT, EMIT, NEXT, FRAME_END);
  - the 8-bit color format constants (red 8'b111_000_00, orange 8'b111_010_00, cyan 8'b011_101_11, purple 8'b111_000_11);
  - screen width constants 640x480.
- One sub-module is natural: heatmap_block_scanner, the sx/sy counter pair with handshake advance and a last-pixel flag.

Test Plan:
- NUM_NODES=4, SCALE=2, RD_LAT=2, ready=1, frame_req pulsed, RAM = {8'hE0,8'hE8,8'h77,8'hE3}, done_write_sig 5 cycles after comp_allow -> 16 pixels; node 2 at (62..63, 4..5) with color 8'h77; frame_done once; frame_count=1.
- Latency check: capture edge exactly 2 cycles after rd_addr changes; RAM model with RD_LAT=2 yields the correct color, RD_LAT=1 mis-model detected.
- pixel_ready toggling 1010... -> outputs stable during stalls; no pixel lost or duplicated; 64*16=1024 handshakes per frame.
- done_write_sig never asserted, DONE_TIMEOUT=20 -> timeout_err=1 at cycle 21 after KICK; no pixel_valid; return to IDLE.
- reset driven low mid-EMIT -> all outputs zero immediately (asynchronous); after release with frame_req=1, comp_allow pulses on the second cycle.
- frame_req held high for 3 frames -> comp_allow pulses 3+ times, gaps of 2 cycles after each frame_done; frame_count preset via forced wrap from 16'hFFFF -> 0.

Source files
------------

// File: rtl/heatmap_pkg.sv
// Shared types and constants for the heatmap colour-buffer reader:
// controller state encoding, RRR_GGG_BB palette and screen geometry.
package heatmap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_WAIT_DONE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_EMIT,
        ST_NEXT,
        ST_FRAME_END
    } hm_state_e;

    localparam logic [7:0] COLOR_RED    = 8'b111_000_00;
    localparam logic [7:0] COLOR_ORANGE = 8'b111_010_00;
    localparam logic [7:0] COLOR_CYAN   = 8'b011_101_11;
    localparam logic [7:0] COLOR_PURPLE = 8'b111_000_11;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Screen coordinate of one pixel inside a node square, truncated to 10 bits.
    function automatic logic [9:0] pix_coord(input logic [9:0] origin,
                                             input logic [9:0] idx,
                                             input logic [9:0] scale,
                                             input logic [2:0] offset);
        return origin + idx * scale + {7'b0, offset};
    endfunction

endpackage

// File: rtl/heatmap_block_scanner.sv
// Raster counter pair (sx, sy) walking one SCALE x SCALE pixel square;
// advances on each accepted pixel and flags the final pixel of the square.
module heatmap_block_scanner #(
    parameter int unsigned SCALE = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       adv_i,
    output logic [2:0] sx_o,
    output logic [2:0] sy_o,
    output logic       last_o
);

    localparam logic [2:0] EDGE_LAST = 3'(SCALE - 1);

    logic [2:0] sx_q, sx_d;
    logic [2:0] sy_q, sy_d;

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (clear_i) begin
            sx_d = '0;
            sy_d = '0;
        end else if (adv_i) begin
            if (sx_q == EDGE_LAST) begin
                sx_d = '0;
                sy_d = (sy_q == EDGE_LAST) ? '0 : sy_q + 3'd1;
            end else begin
                sx_d = sx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sx_q <= '0;
            sy_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    assign sx_o   = sx_q;
    assign sy_o   = sy_q;
    assign last_o = (sx_q == EDGE_LAST) && (sy_q == EDGE_LAST);

endmodule

// File: rtl/heatmap_buffer_reader.sv
// Kicks a writer pass, waits for completion, then reads each node colour
// from the shared RAM and streams it as a SCALE x SCALE pixel square.
module heatmap_buffer_reader
    import heatmap_pkg::*;
#(
    parameter int unsigned NUM_NODES    = 64,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned SCALE        = 4,
    parameter int unsigned COLUMN       = 31,
    parameter int unsigned X_ORIGIN     = 0,
    parameter int unsigned Y_ORIGIN     = 0,
    parameter logic [15:0] DONE_TIMEOUT = 16'hFFFF
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        frame_req,
    output logic        comp_allow,
    input  logic        done_write_sig,
    output logic [7:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [7:0]  pixel_color,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        timeout_err
);

    localparam logic [7:0] NODE_LAST = 8'(NUM_NODES - 1);
    localparam logic [7:0] LAT_LAST  = 8'(RD_LAT - 1);
    localparam logic [7:0] ADDR_BASE = 8'(BASE_ADDR);

    hm_state_e   state_q, state_d;
    logic [7:0]  node_q, node_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  lat_q, lat_d;
    logic [7:0]  color_q, color_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_q, err_d;

    logic        scan_clear, scan_adv, scan_last;
    logic [2:0]  sx, sy;

    heatmap_block_scanner #(
        .SCALE (SCALE)
    ) u_scanner (
        .clk_i   (clk_50),
        .rst_ni  (reset),
        .clear_i (scan_clear),
        .adv_i   (scan_adv),
        .sx_o    (sx),
        .sy_o    (sy),
        .last_o  (scan_last)
    );

    always_comb begin
        state_d     = state_q;
        node_d      = node_q;
        to_cnt_d    = to_cnt_q;
        lat_d       = lat_q;
        color_d     = color_q;
        rd_addr_d   = rd_addr_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        scan_clear  = 1'b0;
        scan_adv    = 1'b0;
        comp_allow  = 1'b0;
        frame_done  = 1'b0;
        pixel_valid = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        pixel_color = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_req) state_d = ST_KICK;
            end
            ST_KICK: begin
                // done_write_sig is not looked at here: the writer clears it on comp_allow
                comp_allow = 1'b1;
                to_cnt_d   = '0;
                state_d    = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_write_sig) begin
                    node_d  = '0;
                    state_d = ST_RD_ISSUE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                    if (to_cnt_d == DONE_TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                rd_addr_d = ADDR_BASE + node_q;
                lat_d     = '0;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    color_d    = rd_data;
                    scan_clear = 1'b1;
                    state_d    = ST_EMIT;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            ST_EMIT: begin
                pixel_valid = 1'b1;
                pixel_x     = pix_coord(10'(X_ORIGIN), 10'(COLUMN), 10'(SCALE), sx);
                pixel_y     = pix_coord(10'(Y_ORIGIN), {2'b0, node_q}, 10'(SCALE), sy);
                pixel_color = color_q;
                scan_adv    = pixel_ready;
                if (pixel_ready && scan_last) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (node_q == NODE_LAST) begin
                    state_d = ST_FRAME_END;
                end else begin
                    node_d  = node_q + 8'd1;
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_FRAME_END: begin
                frame_done  = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            node_q      <= '0;
            to_cnt_q    <= '0;
            lat_q       <= '0;
            color_q     <= '0;
            rd_addr_q   <= ADDR_BASE;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            node_q      <= node_d;
            to_cnt_q    <= to_cnt_d;
            lat_q       <= lat_d;
            color_q     <= color_d;
            rd_addr_q   <= rd_addr_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign frame_count = frame_cnt_q;
    assign timeout_err = err_q;

endmodule
